// File: rtl/ifu_fetch_master.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_master
// Purpose  : AXI4-Lite read initiator for instruction fetch; one fetch in flight
// Revision : 1.0
// ============================================================================
module ifu_fetch_master #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic [31:0] npc,
  input  logic        npc_valid,
  output logic [31:0] fetch_cnt
);

  localparam logic [2:0] BOOT    = 3'd0;
  localparam logic [2:0] AR      = 3'd1;
  localparam logic [2:0] R       = 3'd2;
  localparam logic [2:0] OUT     = 3'd3;
  localparam logic [2:0] WAIT_PC = 3'd4;

  logic [2:0]  state;
  logic [31:0] pc;

  // Handshake outputs are pure state decodes, so no input reaches an output.
  assign arvalid    = (state == AR);
  assign rready     = (state == R);
  assign inst_valid = (state == OUT);
  assign araddr     = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      inst      <= 32'd0;
      inst_pc   <= 32'd0;
      inst_err  <= 1'b0;
      fetch_cnt <= 32'd0;
    end else begin
      case (state)
        BOOT: state <= AR;
        AR: begin
          if (arready) state <= R;
        end
        R: begin
          if (rvalid) begin
            inst      <= rdata;
            inst_pc   <= pc;
            inst_err  <= rresp;
            fetch_cnt <= fetch_cnt + 32'd1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (inst_ready) begin
            if (npc_valid) begin
              pc    <= npc;
              state <= AR;
            end else begin
              state <= WAIT_PC;
            end
          end
        end
        WAIT_PC: begin
          if (npc_valid) begin
            pc    <= npc;
            state <= AR;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
`default_nettype wire
